// File: rtl/ldl_cdc_bus_sched.sv
`default_nettype none
// ============================================================================
// ldl_cdc_bus_sched : round-robin scheduler sharing one toggle-handshake CDC link
// Revision 1.0
// ============================================================================
module ldl_cdc_bus_sched #(
   parameter int N       = 4,
   parameter int WIDTH   = 8,
   parameter int TIMEOUT = 1023,
   localparam int IDW    = (N > 1) ? $clog2(N) : 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [N-1:0]         req_valid,
   input  logic [N*WIDTH-1:0]   req_data,
   output logic [N-1:0]         req_ready,
   output logic [IDW+WIDTH-1:0] link_data,
   output logic                 link_tgl,
   input  logic                 link_ack_tgl,
   output logic                 busy,
   output logic [IDW-1:0]       grant_id,
   output logic                 err_timeout
);

   localparam int              CNTW     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CNTW-1:0] CNT_MAX  = CNTW'(TIMEOUT);
   localparam logic [CNTW-1:0] CNT_LAST = CNTW'(TIMEOUT - 1);

   typedef enum logic [0:0] {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

   state_t                 state_q, state_d;
   logic [IDW-1:0]         ptr_q, ptr_d;
   logic                   tgl_q, tgl_d;
   logic [IDW+WIDTH-1:0]   data_q, data_d;
   logic [IDW-1:0]         gid_q, gid_d;
   logic                   busy_q, busy_d;
   logic                   err_q, err_d;
   logic [CNTW-1:0]        cnt_q, cnt_d;

   logic                   link_ready;
   logic                   found;
   logic [IDW-1:0]         winner;
   logic [IDW:0]           idx;
   logic [WIDTH-1:0]       sel_data;

   assign link_ready = (link_ack_tgl == tgl_q);

   // Scan ptr, ptr+1, ... modulo N; first valid requester wins.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      idx    = '0;
      for (int i = 0; i < N; i++) begin
         idx = {1'b0, ptr_q} + (IDW+1)'(i);
         if (idx >= (IDW+1)'(N)) idx = idx - (IDW+1)'(N);
         if (!found && req_valid[idx[IDW-1:0]]) begin
            found  = 1'b1;
            winner = idx[IDW-1:0];
         end
      end
   end

   always_comb begin
      sel_data = '0;
      for (int k = 0; k < N; k++) begin
         if (winner == IDW'(k)) sel_data = req_data[k*WIDTH +: WIDTH];
      end
   end

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      tgl_d     = tgl_q;
      data_d    = data_q;
      gid_d     = gid_q;
      busy_d    = busy_q;
      err_d     = err_q;
      cnt_d     = cnt_q;
      req_ready = '0;
      case (state_q)
         S_IDLE: begin
            // rst_n gating keeps the grant strobe quiet while reset is held.
            if (rst_n && link_ready && found) begin
               req_ready[winner] = 1'b1;
               data_d  = {winner, sel_data};
               tgl_d   = ~tgl_q;
               gid_d   = winner;
               ptr_d   = (winner == IDW'(N - 1)) ? '0 : winner + 1'b1;
               busy_d  = 1'b1;
               cnt_d   = '0;
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (link_ready) begin
               busy_d  = 1'b0;
               state_d = S_IDLE;
            end else begin
               if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
               if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) err_d = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         ptr_q   <= '0;
         tgl_q   <= 1'b0;
         data_q  <= '0;
         gid_q   <= '0;
         busy_q  <= 1'b0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         tgl_q   <= tgl_d;
         data_q  <= data_d;
         gid_q   <= gid_d;
         busy_q  <= busy_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   assign link_data   = data_q;
   assign link_tgl    = tgl_q;
   assign busy        = busy_q;
   assign grant_id    = gid_q;
   assign err_timeout = err_q;

endmodule
`default_nettype wire

// File: tb/tb_ldl_cdc_bus_sched.sv
`default_nettype none
// ============================================================================
// tb_ldl_cdc_bus_sched : directed self-checking bench for ldl_cdc_bus_sched
// Revision 1.0
// ============================================================================
module tb_ldl_cdc_bus_sched;

   localparam int N     = 4;
   localparam int WIDTH = 8;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [N-1:0]     req_valid = '0;
   logic [N*WIDTH-1:0] req_data = '0;
   logic [N-1:0]     req_ready;
   logic [9:0]       link_data;
   logic             link_tgl;
   logic             link_ack_tgl = 1'b0;
   logic             busy;
   logic [1:0]       grant_id;
   logic             err_timeout;

   int   total = 0;
   int   bad   = 0;
   logic exp_tgl = 1'b0;

   always #5 clk = ~clk;

   ldl_cdc_bus_sched #(.N(N), .WIDTH(WIDTH), .TIMEOUT(8)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid    (req_valid),
      .req_data     (req_data),
      .req_ready    (req_ready),
      .link_data    (link_data),
      .link_tgl     (link_tgl),
      .link_ack_tgl (link_ack_tgl),
      .busy         (busy),
      .grant_id     (grant_id),
      .err_timeout  (err_timeout)
   );

   task automatic do_reset(input logic ack);
      @(negedge clk);
      rst_n = 1'b0;
      req_valid = '0;
      link_ack_tgl = ack;
      @(negedge clk);
      rst_n = 1'b1;
      exp_tgl = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; req_valid = 4'b0001; req_data = '0; link_ack_tgl = 1'b0;
      #2;
      total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL reset_ready: got %b want %b", req_ready, 4'b0000); end
      total++; if (link_data !== 10'h000) begin bad++; $display("FAIL reset_data: got %h want %h", link_data, 10'h000); end
      total++; if (link_tgl !== 1'b0) begin bad++; $display("FAIL reset_tgl: got %b want 0", link_tgl); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
      total++; if (grant_id !== 2'd0) begin bad++; $display("FAIL reset_gid: got %0d want 0", grant_id); end
      total++; if (err_timeout !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", err_timeout); end
      @(negedge clk);
      rst_n = 1'b1; req_valid = '0; exp_tgl = 1'b0;
   endtask

   task automatic test_single();
      req_data = 32'h00A5_0000; req_valid = 4'b0100;
      #1;
      total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL single_ready: got %b want %b", req_ready, 4'b0100); end
      @(negedge clk);
      total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL single_ready_wait: got %b want 0000", req_ready); end
      req_valid = '0; exp_tgl = 1'b1;
      total++; if (link_data !== 10'h2A5) begin bad++; $display("FAIL single_data: got %h want %h", link_data, 10'h2A5); end
      total++; if (link_tgl !== exp_tgl) begin bad++; $display("FAIL single_tgl: got %b want %b", link_tgl, exp_tgl); end
      total++; if (grant_id !== 2'd2) begin bad++; $display("FAIL single_gid: got %0d want 2", grant_id); end
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy1: got %b want 1", busy); end
      @(negedge clk);
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy2: got %b want 1", busy); end
      @(negedge clk);
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy3: got %b want 1", busy); end
      link_ack_tgl = exp_tgl;
      @(negedge clk);
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_busy_end: got %b want 0", busy); end
      total++; if (link_tgl !== 1'b1) begin bad++; $display("FAIL single_tgl_hold: got %b want 1", link_tgl); end
      // ptr is 3 now; requester 0 wins by wrap-around
      req_valid = 4'b0001;
      #1;
      total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL single_next_ready: got %b want 0001", req_ready); end
      @(negedge clk);
      exp_tgl = ~exp_tgl;
      total++; if (grant_id !== 2'd0) begin bad++; $display("FAIL single_next_gid: got %0d want 0", grant_id); end
      req_valid = '0; link_ack_tgl = exp_tgl;
      @(negedge clk);
   endtask

   task automatic test_round_robin();
      logic [1:0] e;
      logic [7:0] pay;
      do_reset(1'b0);
      req_data = 32'h4433_2211; req_valid = 4'b1111;
      for (int k = 0; k < 6; k++) begin
         e = 2'(k % 4);
         pay = req_data[e*8 +: 8];
         #1;
         total++; if (req_ready !== (4'b0001 << e)) begin bad++; $display("FAIL rr_ready[%0d]: got %b want %b", k, req_ready, 4'b0001 << e); end
         @(negedge clk);
         exp_tgl = ~exp_tgl;
         total++; if (grant_id !== e) begin bad++; $display("FAIL rr_gid[%0d]: got %0d want %0d", k, grant_id, e); end
         total++; if (link_data !== {e, pay}) begin bad++; $display("FAIL rr_data[%0d]: got %h want %h", k, link_data, {e, pay}); end
         total++; if (link_tgl !== exp_tgl) begin bad++; $display("FAIL rr_tgl[%0d]: got %b want %b", k, link_tgl, exp_tgl); end
         total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL rr_pulse1[%0d]: got %b want 0000", k, req_ready); end
         @(negedge clk);
         total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL rr_pulse2[%0d]: got %b want 0000", k, req_ready); end
         total++; if (busy !== 1'b1) begin bad++; $display("FAIL rr_busy[%0d]: got %b want 1", k, busy); end
         link_ack_tgl = exp_tgl;
         @(negedge clk);
      end
      req_valid = '0;
   endtask

   task automatic test_ptr_skip();
      logic [3:0] vv [3];
      logic [1:0] ee [3];
      vv = '{4'b0001, 4'b1001, 4'b1001};
      ee = '{2'd0, 2'd3, 2'd0};
      do_reset(1'b0);
      req_data = 32'h4433_2211;
      for (int k = 0; k < 3; k++) begin
         req_valid = vv[k];
         #1;
         total++; if (req_ready !== (4'b0001 << ee[k])) begin bad++; $display("FAIL skip_ready[%0d]: got %b want %b", k, req_ready, 4'b0001 << ee[k]); end
         @(negedge clk);
         exp_tgl = ~exp_tgl;
         total++; if (grant_id !== ee[k]) begin bad++; $display("FAIL skip_gid[%0d]: got %0d want %0d", k, grant_id, ee[k]); end
         req_valid = '0;
         link_ack_tgl = exp_tgl;
         @(negedge clk);
      end
   endtask

   task automatic test_link_not_ready();
      do_reset(1'b1);
      req_valid = 4'b0001;
      for (int k = 0; k < 3; k++) begin
         #1;
         total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL nr_ready[%0d]: got %b want 0000", k, req_ready); end
         total++; if (busy !== 1'b0) begin bad++; $display("FAIL nr_busy[%0d]: got %b want 0", k, busy); end
         @(negedge clk);
      end
      link_ack_tgl = 1'b0;
      #1;
      total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL nr_grant_ready: got %b want 0001", req_ready); end
      @(negedge clk);
      exp_tgl = 1'b1;
      total++; if (grant_id !== 2'd0) begin bad++; $display("FAIL nr_gid: got %0d want 0", grant_id); end
      total++; if (link_tgl !== exp_tgl) begin bad++; $display("FAIL nr_tgl: got %b want %b", link_tgl, exp_tgl); end
      req_valid = '0; link_ack_tgl = exp_tgl;
      @(negedge clk);
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL nr_busy_end: got %b want 0", busy); end
   endtask

   task automatic test_timeout();
      req_data = 32'h4433_2211; req_valid = 4'b0010;
      @(negedge clk);
      exp_tgl = ~exp_tgl;
      req_valid = '0;
      total++; if (grant_id !== 2'd1) begin bad++; $display("FAIL to_gid: got %0d want 1", grant_id); end
      total++; if (err_timeout !== 1'b0) begin bad++; $display("FAIL to_err[1]: got %b want 0", err_timeout); end
      for (int k = 2; k <= 12; k++) begin
         @(negedge clk);
         total++; if (err_timeout !== (k >= 9)) begin bad++; $display("FAIL to_err[%0d]: got %b want %b", k, err_timeout, (k >= 9)); end
         total++; if (busy !== 1'b1) begin bad++; $display("FAIL to_busy[%0d]: got %b want 1", k, busy); end
      end
      link_ack_tgl = exp_tgl;
      @(negedge clk);
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL to_late_ack_busy: got %b want 0", busy); end
      total++; if (err_timeout !== 1'b1) begin bad++; $display("FAIL to_sticky1: got %b want 1", err_timeout); end
      repeat (2) @(negedge clk);
      total++; if (err_timeout !== 1'b1) begin bad++; $display("FAIL to_sticky2: got %b want 1", err_timeout); end
   endtask

   task automatic test_async_reset();
      req_data = 32'h4433_2211; req_valid = 4'b0001;
      @(negedge clk);
      exp_tgl = ~exp_tgl;
      req_valid = '0;
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL ar_busy_pre: got %b want 1", busy); end
      total++; if (link_tgl !== exp_tgl) begin bad++; $display("FAIL ar_tgl_pre: got %b want %b", link_tgl, exp_tgl); end
      #2;
      rst_n = 1'b0;
      #1;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL ar_busy: got %b want 0", busy); end
      total++; if (link_tgl !== 1'b0) begin bad++; $display("FAIL ar_tgl: got %b want 0", link_tgl); end
      total++; if (link_data !== 10'h000) begin bad++; $display("FAIL ar_data: got %h want 000", link_data); end
      total++; if (grant_id !== 2'd0) begin bad++; $display("FAIL ar_gid: got %0d want 0", grant_id); end
      total++; if (err_timeout !== 1'b0) begin bad++; $display("FAIL ar_err: got %b want 0", err_timeout); end
      total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL ar_ready: got %b want 0000", req_ready); end
      @(negedge clk);
      rst_n = 1'b1; link_ack_tgl = 1'b0; exp_tgl = 1'b0; req_valid = 4'b0100;
      #1;
      total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL ar_post_ready: got %b want 0100", req_ready); end
      @(negedge clk);
      exp_tgl = 1'b1;
      total++; if (grant_id !== 2'd2) begin bad++; $display("FAIL ar_post_gid: got %0d want 2", grant_id); end
      total++; if (link_data !== 10'h233) begin bad++; $display("FAIL ar_post_data: got %h want 233", link_data); end
      total++; if (link_tgl !== exp_tgl) begin bad++; $display("FAIL ar_post_tgl: got %b want %b", link_tgl, exp_tgl); end
      req_valid = '0; link_ack_tgl = exp_tgl;
      @(negedge clk);
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL ar_post_done: got %b want 0", busy); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_ptr_skip();
      test_link_not_ready();
      test_timeout();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/ldl_cdc_bus_sched.md
Name: ldl_cdc_bus_sched

Overview:
- Transmit-side scheduler that shares one toggle-handshake CDC bus link among N local requesters.
- Round-robin arbitration picks one requester, tags its payload with the requester ID, launches it on the link, and holds it until the far side's acknowledge toggle returns.
- Sits in the tx clock domain, directly ahead of the link's data register and request-toggle synchroniser.

Parameters:
- N, 4, number of requesters (1..16, non-power-of-2 allowed).
- WIDTH, 8, payload width per requester.
- IDW, derived: max(1, $clog2(N)); requester ID width; not overridable.
- TIMEOUT, 1023, max clk cycles to wait for ack before flagging error; 0 disables the check.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  N  per-requester valid.
- req_data  in  N*WIDTH  payloads, requester k at bits [k*WIDTH +: WIDTH].
- req_ready  out  N  one-hot grant/accept strobe.
- link_data  out  IDW+WIDTH  {id, payload} presented to the link.
- link_tgl  out  1  request toggle; flips once per launched word.
- link_ack_tgl  in  1  ack toggle returned from rx side, already synchronised into clk.
- busy  out  1  high while a word is outstanding.
- grant_id  out  IDW  ID of last granted requester.
- err_timeout  out  1  sticky ack-timeout flag.

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low on rst_n.
- Reset values (all outputs):
  - state IDLE, ptr 0, link_tgl 0, link_data 0, grant_id 0, busy 0, err_timeout 0, timeout counter 0.
  - req_ready all 0 while rst_n low.
- Link ready condition: the link is ready iff link_ack_tgl == link_tgl.
- IDLE state:
  - If link ready and any req_valid, the winner is the first set req_valid scanning ptr, ptr+1, ..., wrapping modulo N.
  - req_ready[winner] is driven high combinationally in that cycle; all other bits stay 0.
  - A transfer is req_valid & req_ready.
  - On the same edge: link_data <= {winner, req_data[winner]}; link_tgl <= ~link_tgl; grant_id <= winner; ptr <= (winner+1) mod N; busy <= 1; go to WAIT.
  - If link not ready (e.g. far side still in reset with a mismatched toggle), no grant is issued and the block stays in IDLE.
- WAIT state:
  - req_ready all 0; link_data and link_tgl held stable.
  - When link_ack_tgl == link_tgl: busy <= 0, go to IDLE.
  - Next grant happens no earlier than the cycle after the return to IDLE, so there is at least one bubble between words.
- Timeout:
  - Counter clears on entry to WAIT and increments each WAIT cycle, saturating.
  - When it reaches TIMEOUT (TIMEOUT != 0), err_timeout <= 1.
  - err_timeout is sticky until rst_n; the FSM stays in WAIT (no retransmit).
  - A late ack still completes normally.
- Requester obligations: hold req_data stable while req_valid is high. Dropping req_valid before grant is legal and loses the slot without penalty.
- Fairness: with all N requesters valid continuously, grants cycle 0,1,...,N-1,0,... A requester waits at most N-1 other transfers.
- N=1: IDW=1, ID field is always 0, ptr stays 0.
- Reset mid-operation: asynchronous clear to reset values. Any outstanding word is abandoned. The link toggle returns to 0, and the rx side must also be reset to resync.

Test Plan:
- Single request: N=4, WIDTH=8, req_valid=4'b0100, req_data[2]=8'hA5, ack returned 3 cycles later -> req_ready=4'b0100 for exactly 1 cycle; link_data=10'h2A5; link_tgl 0->1; busy high 3 cycles; next grant possible 1 cycle after ack.
- Round-robin: all four valid continuously, ack after 2 cycles each -> grant_id sequence 0,1,2,3,0,1; each req_ready pulse exactly 1 cycle.
- Pointer skip: ptr=1 after grant 0, only req_valid[0] and req_valid[3] set -> grant 3, then 0.
- Link not ready: link_ack_tgl=1 with link_tgl=0 after reset, req_valid=4'b0001 -> no req_ready, IDLE held until link_ack_tgl=0, then grant 0.
- Timeout: TIMEOUT=8, ack never returns -> err_timeout rises 8 WAIT cycles after launch and stays high; a later ack returns FSM to IDLE with err_timeout still 1.
- Async reset mid-WAIT: assert rst_n=0 between edges -> all outputs go to reset values immediately, without waiting for clk; after release with ack=0, a new request is granted normally.
